// File: rtl/flag_unit.sv
// Purpose : EX-stage {Z,V,N} flag producer: writes the flag register per opcode,
//           presents F to ID branch logic (forwarded or stall-protected), tracks halt.
// Latency : flag register updates one cycle after commit; F is combinational when forwarding.
// Backpressure: stall_in holds the EX instruction (no write); flag_stall holds ID behind a flag writer.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ex_valid/ex_opcode/alu_result/alu_ovfl   EX instruction and its ALU outputs
//   stall_in, flush                    downstream stall, taken-branch squash of EX
//   id_valid/id_opcode/id_cond         ID instruction (branch detection)
//   F                                  flags {Z,V,N} to branch logic
//   flag_stall                         hold PC/IF/ID, bubble EX
//   halted                             HLT has committed
//   stall_cnt                          saturating count of flag_stall cycles
module flag_unit #(
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [15:0]      alu_result,
    input  logic             alu_ovfl,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_cond,
    output logic [2:0]       F,
    output logic             flag_stall,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_halted;
    logic [2:0]       r_flags;    // {Z,V,N}
    logic [CNT_W-1:0] r_cnt;

    logic       w_run;
    logic       w_addsub;
    logic       w_zonly;
    logic       w_writer;
    logic       w_commit;
    logic       w_ex_writes;
    logic       w_cond_br;
    logic [2:0] w_next_flags;

    assign w_run    = (r_state == S_RUN);
    assign w_addsub = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
    assign w_zonly  = (ex_opcode == OP_XOR) || (ex_opcode == OP_SLL) ||
                      (ex_opcode == OP_SRA) || (ex_opcode == OP_ROR);
    assign w_writer = w_addsub || w_zonly;

    assign w_commit = ex_valid && !flush && !stall_in && w_run;

    // Gated with rst_n so neither the forwarding path nor flag_stall can
    // leak a value while the block is held in reset.
    assign w_ex_writes = rst_n && ex_valid && !flush && w_run && w_writer;

    // C = 111 is the unconditional form and never depends on flags.
    assign w_cond_br = id_valid && ((id_opcode == OP_B) || (id_opcode == OP_BR)) &&
                       (id_cond != 3'b111);

    // Z-only writers keep the held V and N bits.
    assign w_next_flags = {(alu_result == 16'h0000),
                           w_addsub ? alu_ovfl       : r_flags[1],
                           w_addsub ? alu_result[15] : r_flags[0]};

    generate
        if (FORWARD_EN) begin : g_fwd
            assign F          = (w_ex_writes && !stall_in) ? w_next_flags : r_flags;
            assign flag_stall = 1'b0;
        end else begin : g_stall
            assign F          = r_flags;
            assign flag_stall = w_cond_br && w_ex_writes;
        end
    endgenerate

    assign halted    = r_halted;
    assign stall_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_flags  <= 3'b000;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_commit && w_writer) begin
                        r_flags <= w_next_flags;
                    end
                    if (flag_stall && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    if (w_commit && (ex_opcode == OP_HLT)) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    // Terminal: flags and counter frozen until reset.
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the {Z,V,N} flag interface consumed by the branch/PC-control logic in the pipelined 16-bit CPU.
- Sits in the EX stage. It computes flags from the ALU result and writes the architectural flag register per opcode.
- Presents F to the branch logic in ID. It either forwards same-cycle flag updates or stalls ID until they commit.
- Also tracks halt and counts flag-induced stall cycles.

Parameters:
- FORWARD_EN, 1, 1 = forward EX flag update combinationally to F (no stall); 0 = stall ID one cycle instead.
- CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX holds a valid instruction.
- ex_opcode  input  4  opcode of EX instruction.
- alu_result  input  16  EX ALU result.
- alu_ovfl  input  1  signed overflow of EX ADD/SUB.
- stall_in  input  1  downstream stall; EX instruction repeats next cycle.
- flush  input  1  squash EX instruction (taken-branch kill).
- id_valid  input  1  ID holds a valid instruction.
- id_opcode  input  4  opcode of ID instruction.
- id_cond  input  3  branch condition field C of ID instruction.
- F  output  3  flags {Z,V,N} to branch logic.
- flag_stall  output  1  hold PC/IF/ID, bubble EX.
- halted  output  1  HLT has committed in EX.
- stall_cnt  output  CNT_W  number of cycles flag_stall was high.

Behaviour:
- Reset (async, rst_n low): flag register = 3'b000, halted = 0, stall_cnt = 0, state = RUN. flag_stall = 0 while in reset.
- commit = ex_valid & !flush & !stall_in & (state == RUN).
- Writer classes by ex_opcode:
  - ADD 0000 / SUB 0001: write Z, V, N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; V and N hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): no flag write.
- Flag values: Z = (alu_result == 16'h0000); N = alu_result[15]; V = alu_ovfl. alu_ovfl is ignored for non-ADD/SUB.
- The flag register updates on the clock edge where commit is high and the opcode is a writer. One-cycle write latency.
- cond_br = id_valid & (id_opcode == 1100 | id_opcode == 1101) & (id_cond != 3'b111).
- ex_writes = ex_valid & !flush & (state == RUN) & writer(ex_opcode).
- FORWARD_EN = 1:
  - F = next flag value (new bits merged with held bits) when ex_writes & !stall_in; otherwise F = flag register.
  - flag_stall is constant 0.
- FORWARD_EN = 0:
  - F = flag register.
  - flag_stall = cond_br & ex_writes. It stays high while stall_in holds the writer in EX.
  - It falls the cycle after the writer commits, because the writer leaves EX and the bubble occupies it.
- Unconditional branches (C = 111) and non-branch ID instructions never stall.
- State machine:
  - RUN -> HALTED when commit & ex_opcode == 1111.
  - HALTED is terminal; exit only via rst_n.
  - In HALTED: halted = 1, flag register frozen, flag_stall = 0, stall_cnt frozen.
- stall_cnt increments by 1 on each rising edge where flag_stall = 1. It saturates at all-ones.
- Simultaneous flush and writer: no write, no stall.
- stall_in and flush together: flush wins; no write.
- HLT flushed in EX does not halt.
- Reset mid-stall: flag_stall drops immediately (async), and all registers clear.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary inputs -> F = 000, halted = 0, stall_cnt = 0, flag_stall = 0; release -> values hold until first commit.
- ADD commit with alu_result = 16'h8000, alu_ovfl = 1 -> F = {0,1,1} next cycle. Then XOR with result 0, ovfl = 1 -> F = {1,1,1} (V, N held).
- FORWARD_EN = 1:
  - SUB result 0 in EX and ID holding B with C = 001 in the same cycle -> F shows Z = 1 that cycle, flag_stall = 0.
  - FORWARD_EN = 0, same stimulus -> flag_stall = 1 for one cycle, F = {1,x,x} next cycle, stall_cnt = 1.
- FORWARD_EN = 0: ADD in EX with stall_in high for 3 cycles, ID holds BR C = 011 -> flag_stall high 4 cycles; stall_cnt = 4; single flag write.
- Flush: SUB result 0 with flush = 1 -> F unchanged, no stall. HLT with flush = 1 -> halted stays 0.
- HLT commit -> halted = 1 next cycle. A later ADD with ex_valid does not change F. Asserting rst_n low returns halted to 0.
